// File: rtl/icache_refill.sv
// Instruction-cache miss writer: fetches one line over the memory bus, fills the data RAM,
// forwards the critical word, and writes the tag last so a partial line never looks valid.
module icache_refill #(
    parameter int LINE_WORDS = 8,
    parameter int INDEX_W    = 7,
    parameter int TAG_W      = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tag_work,
    input  logic                       miss_req,
    input  logic [31:0]                miss_addr,
    output logic                       busy,
    output logic                       refill_done,
    output logic                       refill_err,
    output logic                       rd_req,
    output logic [31:0]                rd_addr,
    input  logic                       rd_ready,
    input  logic                       ret_valid,
    input  logic [31:0]                ret_data,
    input  logic                       ret_last,
    output logic                       data_wen,
    output logic [INDEX_W+$clog2(LINE_WORDS)-1:0] data_waddr,
    output logic [31:0]                data_wdata,
    output logic [3:0]                 tag_wen,
    output logic [INDEX_W-1:0]         tag_waddr,
    output logic [TAG_W:0]             tag_wdata,
    output logic                       fwd_valid,
    output logic [31:0]                fwd_data
);

    localparam int BEAT_W = $clog2(LINE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_TAG_WR,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [31:2]         r_addr;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_abort;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [BEAT_W-1:0]   w_crit;
    logic                w_beat;
    logic                w_lastSlot;
    logic                w_unused;

    assign w_idx      = r_addr[5+INDEX_W-1:5];
    assign w_tag      = r_addr[31:32-TAG_W];
    assign w_crit     = r_addr[BEAT_W+1:2];
    assign w_beat     = (r_state == S_RECV) && ret_valid;
    assign w_lastSlot = (r_beat == BEAT_W'(LINE_WORDS - 1));
    assign w_unused   = ^miss_addr[1:0];

    assign rd_addr    = {r_addr[31:5], 5'b0};
    assign data_waddr = {w_idx, r_beat};
    assign data_wdata = ret_data;
    assign fwd_data   = ret_data;
    assign tag_waddr  = w_idx;
    assign tag_wdata  = {1'b1, w_tag};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The abort flag records a burst that ended before the final slot so DONE can report it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_beat  <= '0;
            r_abort <= 1'b0;
        end else begin
            if (r_state == S_IDLE && miss_req && tag_work) begin
                r_addr <= miss_addr[31:2];
            end
            if (r_state == S_REQ && rd_ready) begin
                r_beat <= '0;
            end else if (w_beat) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (w_beat && !w_lastSlot && ret_last) begin
                r_abort <= 1'b1;
            end else if (r_state == S_DONE) begin
                r_abort <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (miss_req && tag_work) w_next = S_REQ;
            S_REQ:    if (rd_ready) w_next = S_RECV;
            S_RECV: begin
                if (ret_valid) begin
                    if (w_lastSlot)    w_next = S_TAG_WR;
                    else if (ret_last) w_next = S_DONE;
                end
            end
            S_TAG_WR: w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Strobes are suppressed while rst is high so a reset cycle mid-burst writes nothing.
    always_comb begin
        busy        = 1'b0;
        rd_req      = 1'b0;
        data_wen    = 1'b0;
        fwd_valid   = 1'b0;
        tag_wen     = 4'h0;
        refill_done = 1'b0;
        refill_err  = 1'b0;
        if (!rst) begin
            busy      = (r_state != S_IDLE);
            rd_req    = (r_state == S_REQ);
            data_wen  = w_beat;
            fwd_valid = w_beat && (r_beat == w_crit);
            if (r_state == S_TAG_WR) begin
                tag_wen = 4'hF;
            end
            if (r_state == S_DONE) begin
                refill_done = 1'b1;
                refill_err  = r_abort;
            end
        end
    end

endmodule
